// File: rtl/hms_timekeeper.sv
// hh:mm:ss timekeeper with built-in prescaler, 12h/24h display, field-wise time set
// and six-digit 7-segment decode.
module hms_timekeeper #(
    parameter int unsigned CLK_DIV     = 50_000_000,
    parameter bit          SEG_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_12h,
    input  logic [1:0]  set_sel,
    input  logic        set_inc,
    output logic [7:0]  hh_bcd,
    output logic [7:0]  mm_bcd,
    output logic [7:0]  ss_bcd,
    output logic        pm,
    output logic        tick_1hz,
    output logic        min_tick,
    output logic        hour_tick,
    output logic        day_tick,
    output logic [41:0] segs
);

    localparam int unsigned PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    localparam logic [1:0] SEL_RUN = 2'b00;
    localparam logic [1:0] SEL_HH  = 2'b01;
    localparam logic [1:0] SEL_MM  = 2'b10;
    localparam logic [1:0] SEL_SS  = 2'b11;

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    ss_u_q, ss_u_d, ss_t_q, ss_t_d;
    logic [3:0]    mm_u_q, mm_u_d, mm_t_q, mm_t_d;
    logic [4:0]    hour_q, hour_d;

    logic running, tick, ss_at_59, mm_at_59, hr_at_23;

    assign running  = (set_sel == SEL_RUN);
    assign tick     = running && (presc_q == PRESC_MAX);
    assign ss_at_59 = (ss_t_q == 4'd5) && (ss_u_q == 4'd9);
    assign mm_at_59 = (mm_t_q == 4'd5) && (mm_u_q == 4'd9);
    assign hr_at_23 = (hour_q == 5'd23);

    assign tick_1hz  = tick;
    assign min_tick  = tick && ss_at_59;
    assign hour_tick = min_tick && mm_at_59;
    assign day_tick  = hour_tick && hr_at_23;

    // Next-state: run-mode carry chain, or single-field edits in set mode
    always_comb begin
        presc_d = presc_q;
        ss_u_d  = ss_u_q;
        ss_t_d  = ss_t_q;
        mm_u_d  = mm_u_q;
        mm_t_d  = mm_t_q;
        hour_d  = hour_q;

        if (!running) begin
            presc_d = '0;
        end else if (tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (tick) begin
            if (ss_u_q == 4'd9) begin
                ss_u_d = 4'd0;
                ss_t_d = (ss_t_q == 4'd5) ? 4'd0 : ss_t_q + 4'd1;
            end else begin
                ss_u_d = ss_u_q + 4'd1;
            end
        end

        if (tick && ss_at_59) begin
            if (mm_u_q == 4'd9) begin
                mm_u_d = 4'd0;
                mm_t_d = (mm_t_q == 4'd5) ? 4'd0 : mm_t_q + 4'd1;
            end else begin
                mm_u_d = mm_u_q + 4'd1;
            end
        end

        if (tick && ss_at_59 && mm_at_59) begin
            hour_d = hr_at_23 ? 5'd0 : hour_q + 5'd1;
        end

        if (set_inc) begin
            case (set_sel)
                SEL_HH: hour_d = hr_at_23 ? 5'd0 : hour_q + 5'd1;
                SEL_MM: begin
                    if (mm_u_q == 4'd9) begin
                        mm_u_d = 4'd0;
                        mm_t_d = (mm_t_q == 4'd5) ? 4'd0 : mm_t_q + 4'd1;
                    end else begin
                        mm_u_d = mm_u_q + 4'd1;
                    end
                end
                SEL_SS: begin
                    ss_u_d = 4'd0;
                    ss_t_d = 4'd0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            ss_u_q  <= 4'd0;
            ss_t_q  <= 4'd0;
            mm_u_q  <= 4'd0;
            mm_t_q  <= 4'd0;
            hour_q  <= 5'd0;
        end else begin
            presc_q <= presc_d;
            ss_u_q  <= ss_u_d;
            ss_t_q  <= ss_t_d;
            mm_u_q  <= mm_u_d;
            mm_t_q  <= mm_t_d;
            hour_q  <= hour_d;
        end
    end

    // Display hour: 12h maps 0->12 and 13..23 -> 1..11; then binary to BCD
    logic [4:0] hour_disp;
    logic [3:0] hh_t, hh_u;

    always_comb begin
        hour_disp = hour_q;
        if (mode_12h) begin
            if (hour_q == 5'd0) begin
                hour_disp = 5'd12;
            end else if (hour_q > 5'd12) begin
                hour_disp = hour_q - 5'd12;
            end
        end
        if (hour_disp >= 5'd20) begin
            hh_t = 4'd2;
            hh_u = 4'(hour_disp - 5'd20);
        end else if (hour_disp >= 5'd10) begin
            hh_t = 4'd1;
            hh_u = 4'(hour_disp - 5'd10);
        end else begin
            hh_t = 4'd0;
            hh_u = 4'(hour_disp);
        end
    end

    assign hh_bcd = {hh_t, hh_u};
    assign mm_bcd = {mm_t_q, mm_u_q};
    assign ss_bcd = {ss_t_q, ss_u_q};
    assign pm     = (hour_q >= 5'd12);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h00;
        endcase
        return SEG_ACT_LOW ? ~p : p;
    endfunction

    assign segs = {seg7(hh_t), seg7(hh_u), seg7(mm_t_q), seg7(mm_u_q),
                   seg7(ss_t_q), seg7(ss_u_q)};

endmodule

// File: tb/tb_hms_timekeeper.sv
// Directed bench for hms_timekeeper with CLK_DIV=4 and active-low segments.
module tb_hms_timekeeper;

    logic        clk = 1'b0;
    logic        reset;
    logic        mode_12h;
    logic [1:0]  set_sel;
    logic        set_inc;
    logic [7:0]  hh_bcd, mm_bcd, ss_bcd;
    logic        pm, tick_1hz, min_tick, hour_tick, day_tick;
    logic [41:0] segs;

    int n_cmp = 0;
    int n_err = 0;
    logic any_tick;

    hms_timekeeper #(.CLK_DIV(4), .SEG_ACT_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .mode_12h(mode_12h), .set_sel(set_sel),
        .set_inc(set_inc), .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd),
        .pm(pm), .tick_1hz(tick_1hz), .min_tick(min_tick), .hour_tick(hour_tick),
        .day_tick(day_tick), .segs(segs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1);
        reset = 1'b0;
    endtask

    // n consecutive set_inc cycles on the chosen field; records any tick seen
    task automatic pulse(input logic [1:0] sel, input int n);
        set_sel = sel;
        set_inc = 1'b1;
        repeat (n) begin
            any_tick = any_tick | tick_1hz | min_tick | hour_tick | day_tick;
            step(1);
        end
        set_inc = 1'b0;
        any_tick = any_tick | tick_1hz | min_tick | hour_tick | day_tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; mode_12h = 1'b0; set_sel = 2'b00; set_inc = 1'b0;
        any_tick = 1'b0;

        // 1. reset state, then two ticks in 8 cycles
        step(3);
        chk("rst_hh24", hh_bcd, 8'h00);
        chk("rst_mm", mm_bcd, 8'h00);
        chk("rst_ss", ss_bcd, 8'h00);
        chk("rst_ticks", {tick_1hz, min_tick, hour_tick, day_tick, pm}, 5'b0);
        mode_12h = 1'b1;
        #1 chk("rst_hh12", hh_bcd, 8'h12);
        mode_12h = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t1_tick", tick_1hz, ((i % 4) == 3) ? 1'b1 : 1'b0);
            step(1);
        end
        chk("t1_ss", ss_bcd, 8'h02);

        // 2. seconds wrap into minutes
        do_reset();
        step(232);
        chk("t2_ss58", ss_bcd, 8'h58);
        step(3);
        chk("t2_tick58", {tick_1hz, min_tick}, 2'b10);
        step(1);
        chk("t2_ss59", ss_bcd, 8'h59);
        step(3);
        chk("t2_wrap", {tick_1hz, min_tick, hour_tick}, 3'b110);
        step(1);
        chk("t2_ss00", ss_bcd, 8'h00);
        chk("t2_mm01", mm_bcd, 8'h01);

        // 3. 23:59:59 -> 00:00:00 with all four pulses
        do_reset();
        pulse(2'b01, 23);
        pulse(2'b10, 59);
        pulse(2'b11, 1);
        set_sel = 2'b00;
        chk("t3_set", {hh_bcd, mm_bcd, ss_bcd}, 24'h235900);
        step(236);
        chk("t3_ss59", ss_bcd, 8'h59);
        step(3);
        chk("t3_all4", {tick_1hz, min_tick, hour_tick, day_tick}, 4'hF);
        step(1);
        chk("t3_mid", {hh_bcd, mm_bcd, ss_bcd}, 24'h000000);
        chk("t3_quiet", {tick_1hz, min_tick, hour_tick, day_tick}, 4'h0);

        // 4. 12h display mapping
        do_reset();
        pulse(2'b01, 13);
        set_sel = 2'b00;
        mode_12h = 1'b1;
        #1 chk("t4_h13", {hh_bcd, 7'b0, pm}, {8'h01, 7'b0, 1'b1});
        pulse(2'b01, 11);
        chk("t4_h0", {hh_bcd, 7'b0, pm}, {8'h12, 7'b0, 1'b0});
        mode_12h = 1'b0;
        #1 chk("t4_h0_24", hh_bcd, 8'h00);
        mode_12h = 1'b1;
        pulse(2'b01, 12);
        chk("t4_h12", {hh_bcd, 7'b0, pm}, {8'h12, 7'b0, 1'b1});
        pulse(2'b01, 11);
        chk("t4_h23", hh_bcd, 8'h11);
        mode_12h = 1'b0;
        #1 chk("t4_h23_24", hh_bcd, 8'h23);
        set_sel = 2'b00;

        // 5. set mode: hour wrap, minute wrap without carry, seconds clear
        do_reset();
        step(12);
        chk("t5_ss03", ss_bcd, 8'h03);
        any_tick = 1'b0;
        pulse(2'b01, 25);
        chk("t5_hh01", hh_bcd, 8'h01);
        chk("t5_ss_hold", ss_bcd, 8'h03);
        pulse(2'b10, 60);
        chk("t5_mm00", mm_bcd, 8'h00);
        chk("t5_hh_nocarry", hh_bcd, 8'h01);
        chk("t5_noticks", any_tick, 1'b0);
        pulse(2'b11, 1);
        chk("t5_ssclr", ss_bcd, 8'h00);

        // 6. full second after leaving set mode; reset mid-count
        set_sel = 2'b00;
        for (int i = 0; i < 4; i++) begin
            chk("t6_exit_tick", tick_1hz, (i == 3) ? 1'b1 : 1'b0);
            step(1);
        end
        chk("t6_ss01", ss_bcd, 8'h01);
        step(2);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_rst_time", {hh_bcd, mm_bcd, ss_bcd}, 24'h000000);
        for (int i = 0; i < 4; i++) begin
            chk("t6_rst_tick", tick_1hz, (i == 3) ? 1'b1 : 1'b0);
            step(1);
        end

        // segment decode, active-low
        do_reset();
        step(28);
        chk("seg_ss07", ss_bcd, 8'h07);
        chk("seg_ss_u", segs[6:0], 7'h78);
        chk("seg_ss_t", segs[13:7], 7'h40);
        mode_12h = 1'b1;
        #1 chk("seg_hh_t", segs[41:35], 7'h79);
        chk("seg_hh_u", segs[34:28], 7'h24);
        mode_12h = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
